// File: rtl/lift2_plant_pkg.sv
// Shared types and bit-index constants for the lift2 plant model.
package lift2_plant_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DOOR_OPENING,
        DOOR_OPEN,
        DOOR_CLOSING,
        MOVING,
        LEVELING
    } plant_state_t;

    // Command bit indices: cmd[i-1] = y_i
    localparam int CMD_CALL_ACK   = 0;
    localparam int CMD_DIR_DOWN   = 1;
    localparam int CMD_DIR_UP     = 2;
    localparam int CMD_MOTOR_EN   = 3;
    localparam int CMD_DOOR_OPEN  = 4;
    localparam int CMD_DOOR_CLOSE = 9;
    localparam int CMD_STOP       = 10;

    // Sensor bit indices: sns[i-1] = x_i
    localparam int SNS_CALL_PEND   = 0;
    localparam int SNS_DOOR_CLOSED = 1;
    localparam int SNS_TGT_ABOVE   = 2;
    localparam int SNS_TGT_BELOW   = 3;
    localparam int SNS_OVERLOAD    = 4;
    localparam int SNS_DOOR_OPEN   = 5;
    localparam int SNS_AT_TARGET   = 6;
    localparam int SNS_TMR_LAST    = 7;
    localparam int SNS_AT_LIMIT    = 8;
    localparam int SNS_OBSTRUCT    = 9;
    localparam int SNS_READY       = 10;
    localparam int SNS_LEVELING    = 11;
    localparam int SNS_MOVING      = 12;
    localparam int SNS_ESTOP       = 13;

endpackage

// File: rtl/lift2_plant_if.sv
// Controller <-> plant bundle. The master drives commands and environment
// conditions; the slave (the plant) returns sensors, floor and error flag.
interface lift2_plant_if #(
    parameter int FLOOR_W = 3
);
    logic [15:0]        cmd;
    logic               call_req;
    logic [FLOOR_W-1:0] call_floor;
    logic               overload;
    logic               obstruct;
    logic               estop;
    logic [13:0]        sns;
    logic [FLOOR_W-1:0] floor_pos;
    logic               err;

    modport master (
        output cmd, call_req, call_floor, overload, obstruct, estop,
        input  sns, floor_pos, err
    );

    modport slave (
        input  cmd, call_req, call_floor, overload, obstruct, estop,
        output sns, floor_pos, err
    );
endinterface

// File: rtl/lift2_plant_timer.sv
// Load/decrement down-counter; last is high while the count equals 1,
// which is the edge on which a timed state exits.
module lift2_plant_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);
    logic [W-1:0] count;

    // Load wins; otherwise count down and rest at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign last = (count == W'(1));
endmodule

// File: rtl/lift2_plant.sv
// Registered lift model answering the lift2 controller: decodes y commands,
// tracks car/target floor, door and motor state, and drives x sensors.
module lift2_plant
    import lift2_plant_pkg::*;
#(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3,
    parameter int DOOR_T  = 4,
    parameter int FLOOR_T = 6,
    parameter int LEVEL_T = 2
) (
    input logic          clk,
    input logic          rst,
    lift2_plant_if.slave bus
);
    localparam int TMAX = (DOOR_T > FLOOR_T) ? ((DOOR_T > LEVEL_T) ? DOOR_T : LEVEL_T)
                                             : ((FLOOR_T > LEVEL_T) ? FLOOR_T : LEVEL_T);
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(FLOORS - 1);

    plant_state_t       state, nxt;
    logic [FLOOR_W-1:0] pos, target;
    logic               call_pend, move_up, dir_nxt;
    logic               ovl_r, obs_r, est_r;
    logic               tmr_load, tmr_last, step, err_set;
    logic [TW-1:0]      tmr_val;

    logic stop, door_open, door_close, motor, up, dn;
    assign stop       = bus.cmd[CMD_STOP];
    assign door_open  = bus.cmd[CMD_DOOR_OPEN];
    assign door_close = bus.cmd[CMD_DOOR_CLOSE];
    assign motor      = bus.cmd[CMD_MOTOR_EN];
    assign up         = bus.cmd[CMD_DIR_UP];
    assign dn         = bus.cmd[CMD_DIR_DOWN];

    logic unused_cmd;
    assign unused_cmd = ^{bus.cmd[15:11], bus.cmd[8:5]};

    lift2_plant_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .last     (tmr_last)
    );

    // Transition decode; the timer must be loaded on the same edge the state changes.
    always_comb begin
        nxt      = state;
        dir_nxt  = move_up;
        tmr_load = 1'b0;
        tmr_val  = '0;
        step     = 1'b0;
        err_set  = 1'b0;
        case (state)
            IDLE: begin
                if (!stop) begin
                    if (door_open) begin
                        nxt      = DOOR_OPENING;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(DOOR_T);
                    end else if (motor) begin
                        if (up && !dn && pos != TOP) begin
                            nxt      = MOVING;
                            dir_nxt  = 1'b1;
                            tmr_load = 1'b1;
                            tmr_val  = TW'(FLOOR_T);
                        end else if (dn && !up && pos != '0) begin
                            nxt      = MOVING;
                            dir_nxt  = 1'b0;
                            tmr_load = 1'b1;
                            tmr_val  = TW'(FLOOR_T);
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                end
            end
            DOOR_OPENING: begin
                if (tmr_last) nxt = DOOR_OPEN;
            end
            DOOR_OPEN: begin
                if (!stop && door_close && !obs_r) begin
                    nxt      = DOOR_CLOSING;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(DOOR_T);
                end
            end
            DOOR_CLOSING: begin
                if (obs_r) begin
                    nxt      = DOOR_OPENING;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(DOOR_T);
                end else if (tmr_last) begin
                    nxt = IDLE;
                end
            end
            MOVING: begin
                err_set = door_open;
                if (stop || est_r) begin
                    nxt      = LEVELING;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(LEVEL_T);
                end else if (tmr_last) begin
                    nxt      = LEVELING;
                    step     = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(LEVEL_T);
                end
            end
            LEVELING: begin
                if (tmr_last) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Plant state registers: FSM, position, call tracking, sticky error, input syncs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pos       <= '0;
            target    <= '0;
            call_pend <= 1'b0;
            move_up   <= 1'b0;
            bus.err   <= 1'b0;
            ovl_r     <= 1'b0;
            obs_r     <= 1'b0;
            est_r     <= 1'b0;
        end else begin
            state   <= nxt;
            move_up <= dir_nxt;
            if (step) pos <= move_up ? pos + FLOOR_W'(1) : pos - FLOOR_W'(1);
            if (err_set) bus.err <= 1'b1;
            if (bus.call_req) begin
                target    <= (bus.call_floor > TOP) ? TOP : bus.call_floor;
                call_pend <= 1'b1;
            end else if (bus.cmd[CMD_CALL_ACK]) begin
                call_pend <= 1'b0;
            end
            ovl_r <= bus.overload;
            obs_r <= bus.obstruct;
            est_r <= bus.estop;
        end
    end

    // Sensors are decoded from registered state only.
    always_comb begin
        bus.sns                  = '0;
        bus.sns[SNS_CALL_PEND]   = call_pend;
        bus.sns[SNS_DOOR_CLOSED] = (state == IDLE) || (state == MOVING) || (state == LEVELING);
        bus.sns[SNS_TGT_ABOVE]   = target > pos;
        bus.sns[SNS_TGT_BELOW]   = target < pos;
        bus.sns[SNS_OVERLOAD]    = ovl_r;
        bus.sns[SNS_DOOR_OPEN]   = state == DOOR_OPEN;
        bus.sns[SNS_AT_TARGET]   = target == pos;
        bus.sns[SNS_TMR_LAST]    = tmr_last;
        bus.sns[SNS_AT_LIMIT]    = (pos == '0) || (pos == TOP);
        bus.sns[SNS_OBSTRUCT]    = obs_r;
        bus.sns[SNS_READY]       = (state == IDLE) && !call_pend && (target == pos);
        bus.sns[SNS_LEVELING]    = state == LEVELING;
        bus.sns[SNS_MOVING]      = state == MOVING;
        bus.sns[SNS_ESTOP]       = est_r;
    end

    assign bus.floor_pos = pos;
endmodule

// File: tb/tb_lift2_plant.sv
// Closed-loop style bench for lift2_plant: directed command sequences, a
// phase/remaining-cycles lift model checked every cycle, and literal spot checks.
module tb_lift2_plant;
    localparam int FLOORS  = 6;
    localparam int FLOOR_W = 3;
    localparam int DOOR_T  = 4;
    localparam int FLOOR_T = 6;
    localparam int LEVEL_T = 2;

    localparam logic [15:0] Y1  = 16'h0001;
    localparam logic [15:0] Y2  = 16'h0002;
    localparam logic [15:0] Y3  = 16'h0004;
    localparam logic [15:0] Y4  = 16'h0008;
    localparam logic [15:0] Y5  = 16'h0010;
    localparam logic [15:0] Y10 = 16'h0200;
    localparam logic [15:0] Y11 = 16'h0400;

    localparam int M_IDLE = 0, M_OPENING = 1, M_OPEN = 2, M_CLOSING = 3, M_MOVE = 4, M_LEVEL = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lift2_plant_if #(.FLOOR_W(FLOOR_W)) bus ();

    lift2_plant #(
        .FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .DOOR_T(DOOR_T), .FLOOR_T(FLOOR_T), .LEVEL_T(LEVEL_T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Lift model: a phase, cycles remaining in it, and the floor bookkeeping.
    int m_mode = M_IDLE, m_left = 0, m_pos = 0, m_tgt = 0, m_dir = 0;
    bit m_pend = 0, m_err = 0, m_ovl = 0, m_obs = 0, m_est = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = M_IDLE; m_left = 0; m_pos = 0; m_tgt = 0; m_dir = 0;
            m_pend = 0; m_err = 0; m_ovl = 0; m_obs = 0; m_est = 0;
        end else begin
            logic [15:0] c;
            int n_mode, n_left, n_pos, n_dir;
            c = bus.cmd;
            n_mode = m_mode; n_left = m_left; n_pos = m_pos; n_dir = m_dir;
            case (m_mode)
                M_IDLE: if (!c[10]) begin
                    if (c[4]) begin
                        n_mode = M_OPENING; n_left = DOOR_T;
                    end else if (c[3]) begin
                        if (c[2] && !c[1] && m_pos < FLOORS - 1) begin
                            n_mode = M_MOVE; n_left = FLOOR_T; n_dir = 1;
                        end else if (c[1] && !c[2] && m_pos > 0) begin
                            n_mode = M_MOVE; n_left = FLOOR_T; n_dir = -1;
                        end else m_err = 1;
                    end
                end
                M_OPENING: begin
                    n_left = m_left - 1;
                    if (m_left == 1) n_mode = M_OPEN;
                end
                M_OPEN: if (!c[10] && c[9] && !m_obs) begin
                    n_mode = M_CLOSING; n_left = DOOR_T;
                end
                M_CLOSING: begin
                    n_left = m_left - 1;
                    if (m_obs) begin
                        n_mode = M_OPENING; n_left = DOOR_T;
                    end else if (m_left == 1) n_mode = M_IDLE;
                end
                M_MOVE: begin
                    if (c[4]) m_err = 1;
                    n_left = m_left - 1;
                    if (c[10] || m_est) begin
                        n_mode = M_LEVEL; n_left = LEVEL_T;
                    end else if (m_left == 1) begin
                        n_mode = M_LEVEL; n_left = LEVEL_T; n_pos = m_pos + m_dir;
                    end
                end
                default: begin
                    n_left = m_left - 1;
                    if (m_left == 1) n_mode = M_IDLE;
                end
            endcase
            m_mode = n_mode; m_left = n_left; m_pos = n_pos; m_dir = n_dir;
            if (bus.call_req) begin
                m_tgt  = (int'(bus.call_floor) > FLOORS - 1) ? FLOORS - 1 : int'(bus.call_floor);
                m_pend = 1;
            end else if (c[0]) m_pend = 0;
            m_ovl = bus.overload; m_obs = bus.obstruct; m_est = bus.estop;
        end
    end

    function automatic logic [13:0] model_sns();
        logic [13:0] s;
        s     = '0;
        s[0]  = m_pend;
        s[1]  = (m_mode == M_IDLE) || (m_mode == M_MOVE) || (m_mode == M_LEVEL);
        s[2]  = m_tgt > m_pos;
        s[3]  = m_tgt < m_pos;
        s[4]  = m_ovl;
        s[5]  = m_mode == M_OPEN;
        s[6]  = m_tgt == m_pos;
        s[7]  = m_left == 1;
        s[8]  = (m_pos == 0) || (m_pos == FLOORS - 1);
        s[9]  = m_obs;
        s[10] = (m_mode == M_IDLE) && !m_pend && (m_tgt == m_pos);
        s[11] = m_mode == M_LEVEL;
        s[12] = m_mode == M_MOVE;
        s[13] = m_est;
        return s;
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checks++;
        if (bus.sns !== model_sns()) begin
            errors++;
            $display("FAIL model_sns t=%0t got %b want %b", $time, bus.sns, model_sns());
        end
        checks++;
        if (int'(bus.floor_pos) != m_pos || $isunknown(bus.floor_pos)) begin
            errors++;
            $display("FAIL model_pos t=%0t got %0d want %0d", $time, bus.floor_pos, m_pos);
        end
        checks++;
        if (bus.err !== m_err) begin
            errors++;
            $display("FAIL model_err t=%0t got %b want %b", $time, bus.err, m_err);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [15:0] c);
        bus.cmd = c;
        @(negedge clk);
        #1;
        bus.call_req = 1'b0;
    endtask

    task automatic call(input int f);
        bus.call_req   = 1'b1;
        bus.call_floor = FLOOR_W'(f);
        step(16'h0);
    endtask

    task automatic move(input logic [15:0] c);
        step(c);
        repeat (8) step(16'h0);
    endtask

    initial begin
        bus.cmd = '0; bus.call_req = 0; bus.call_floor = '0;
        bus.overload = 0; bus.obstruct = 0; bus.estop = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_sns", int'(bus.sns), 14'b00010101000010);
        chk("reset_pos", int'(bus.floor_pos), 0);
        chk("reset_err", int'(bus.err), 0);

        // Door cycle
        step(Y5);
        chk("door_x2_k", int'(bus.sns[1]), 0);
        repeat (3) step(16'h0);
        chk("door_x6_k3", int'(bus.sns[5]), 0);
        step(16'h0);
        chk("door_x6_k4", int'(bus.sns[5]), 1);
        step(16'h0);
        step(Y10);
        chk("door_x6_close", int'(bus.sns[5]), 0);
        repeat (3) step(16'h0);
        chk("door_x2_k9", int'(bus.sns[1]), 0);
        step(16'h0);
        chk("door_x2_k10", int'(bus.sns[1]), 1);

        // Call and move one floor
        call(2);
        chk("call_x1", int'(bus.sns[0]), 1);
        chk("call_x3", int'(bus.sns[2]), 1);
        step(Y1);
        chk("ack_x1", int'(bus.sns[0]), 0);
        step(Y4 | Y3);
        chk("move_x13_k", int'(bus.sns[12]), 1);
        repeat (5) step(16'h0);
        chk("move_x13_k5", int'(bus.sns[12]), 1);
        chk("move_pos_k5", int'(bus.floor_pos), 0);
        step(16'h0);
        chk("move_pos_k6", int'(bus.floor_pos), 1);
        chk("move_x12_k6", int'(bus.sns[11]), 1);
        step(16'h0);
        chk("move_x12_k7", int'(bus.sns[11]), 1);
        step(16'h0);
        chk("move_idle_k8", int'(bus.sns[12:11]), 0);
        move(Y4 | Y3);
        chk("arrive_x7", int'(bus.sns[6]), 1);
        chk("arrive_x11", int'(bus.sns[10]), 1);

        // Obstruction during closing
        step(Y5);
        repeat (4) step(16'h0);
        step(Y10);
        bus.obstruct = 1'b1;
        step(16'h0);
        step(16'h0);
        chk("obs_reopen_x6", int'(bus.sns[5]), 0);
        chk("obs_x10", int'(bus.sns[9]), 1);
        repeat (3) step(16'h0);
        chk("obs_open_early", int'(bus.sns[5]), 0);
        step(16'h0);
        chk("obs_open_t4", int'(bus.sns[5]), 1);
        step(Y10);
        step(Y10);
        chk("obs_y10_ignored", int'(bus.sns[5]), 1);
        bus.obstruct = 1'b0;
        step(16'h0);
        step(Y10);
        chk("obs_clear_close", int'(bus.sns[5]), 0);
        repeat (5) step(16'h0);
        chk("obs_idle", int'(bus.sns[1]), 1);

        // Emergency stop at cycle 3 of a floor move
        step(Y4 | Y3);
        step(16'h0);
        bus.estop = 1'b1;
        step(16'h0);
        step(16'h0);
        chk("estop_x12", int'(bus.sns[11]), 1);
        chk("estop_x14", int'(bus.sns[13]), 1);
        chk("estop_pos", int'(bus.floor_pos), 2);
        bus.estop = 1'b0;
        repeat (3) step(16'h0);
        chk("estop_idle_pos", int'(bus.floor_pos), 2);

        // Call clamped to top floor, then drive into the limit
        call(7);
        chk("clamp_x3", int'(bus.sns[2]), 1);
        repeat (3) move(Y4 | Y3);
        chk("clamp_pos", int'(bus.floor_pos), 5);
        chk("clamp_x7", int'(bus.sns[6]), 1);
        chk("clamp_x9", int'(bus.sns[8]), 1);
        step(Y4 | Y3);
        chk("top_err", int'(bus.err), 1);
        chk("top_no_move", int'(bus.sns[12]), 0);
        step(Y11 | Y4 | Y2);
        chk("stop_idle_hold", int'(bus.sns[12]), 0);

        // Reset mid-motion
        step(Y4 | Y2);
        repeat (3) step(16'h0);
        rst = 1'b0;
        #1;
        chk("midrst_pos", int'(bus.floor_pos), 0);
        chk("midrst_sns", int'(bus.sns), 14'b00010101000010);
        chk("midrst_err", int'(bus.err), 0);
        @(negedge clk);
        #1;
        rst = 1'b1;

        // Illegal commands
        step(Y4 | Y2);
        chk("ill_down_err", int'(bus.err), 1);
        chk("ill_down_x11", int'(bus.sns[10]), 1);
        step(Y4 | Y3 | Y2);
        chk("ill_both_err", int'(bus.err), 1);
        step(Y4);
        chk("ill_none_x13", int'(bus.sns[12]), 0);
        rst = 1'b0;
        #1;
        chk("ill_rst_err", int'(bus.err), 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        step(16'h0);
        step(16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
